universal_shift_reg: RTL and testbench

Parametrised successor to the lab's single-bit D storage elements: a WIDTH-bit positive-edge register with hold, shift-right, shift-left and parallel-load modes. Adds a burst-shift engine that performs a programmed number of shifts autonomously, with Busy and Done status. Used as the general-purpose storage/serialiser block for later labs (serial links, LED chasers, multiply-by-shift datapaths).

---
 rtl/universal_shift_reg.sv | 130 +++++++++++++
 tb/tb_universal_shift_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   WIDTH-bit register with hold / shift-right / shift-left / parallel-load
//   modes. It also has a burst engine that performs Count shifts on its own
//   and reports Busy and Done.
//
//   Optional feature macro: ROTATE_EN. When it is defined, the Rot input
//   exists and Rot=1 makes every shift a rotate.
//
// Ports
//   Clock   : system clock, posedge
//   Reset   : synchronous, active-high
//   Mode    : 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D       : parallel load data
//   SerIn   : fill bit for shifts
//   Start   : begin a burst (only looked at in IDLE, with Mode 01/10 and Count>0)
//   Count   : burst length, clamped to WIDTH
//   Rot     : (ROTATE_EN only) rotate instead of filling from SerIn
//   Q       : register contents
//   SerOut  : bit that left the register on the most recent shift
//   Busy    : burst in progress
//   Done    : one-cycle pulse, one cycle after the final burst shift
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerIn,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
`ifdef ROTATE_EN
  input  logic             Rot,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [CW-1:0]   rem;       // shifts still to do in BURST
  logic            dir_r;     // latched direction, 1 = right
  logic            fin;       // final shift happened last edge; Done follows
`ifdef ROTATE_EN
  logic            rot_q;     // latched Rot for the burst
`endif

  logic [CW-1:0]    cnt_c;
  logic             right, rot_eff, fill, so_shift, start_ok;
  logic [WIDTH-1:0] q_shift;

  assign cnt_c = (int'(Count) > WIDTH) ? CW'(WIDTH) : Count;

  // A single shifter serves both the single-step modes and the burst. In BURST
  // the direction and rotate come from the latched copies. In IDLE they come
  // from the live inputs.
  always_comb begin
    right = (state == BURST) ? dir_r : (Mode == 2'b01);
`ifdef ROTATE_EN
    rot_eff = (state == BURST) ? rot_q : Rot;
`else
    rot_eff = 1'b0;
`endif
    so_shift = right ? Q[0] : Q[WIDTH-1];
    fill     = rot_eff ? so_shift : SerIn;
    q_shift  = right ? {fill, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], fill};
    start_ok = (state == IDLE) && Start && (Mode == 2'b01 || Mode == 2'b10) &&
               (cnt_c != '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      Q      <= '0;
      SerOut <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      fin    <= 1'b0;
      rem    <= '0;
      dir_r  <= 1'b0;
`ifdef ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      Done <= fin;
      fin  <= 1'b0;
      case (state)
        IDLE: begin
          case (Mode)
            2'b00: ;
            2'b01, 2'b10: begin
              Q      <= q_shift;
              SerOut <= so_shift;
            end
            2'b11: Q <= D;
          endcase
          // The first burst shift is the Mode step above, which happens on this edge.
          if (start_ok) begin
            dir_r <= (Mode == 2'b01);
`ifdef ROTATE_EN
            rot_q <= Rot;
`endif
            if (cnt_c == CW'(1)) begin
              fin <= 1'b1;
            end else begin
              state <= BURST;
              rem   <= cnt_c - CW'(1);
              Busy  <= 1'b1;
            end
          end
        end
        BURST: begin
          Q      <= q_shift;
          SerOut <= so_shift;
          rem    <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            fin   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic [1:0]       Mode  = 2'b00;
  logic [WIDTH-1:0] D     = '0;
  logic             SerIn = 1'b0;
  logic             Start = 1'b0;
  logic [CW-1:0]    Count = '0;
  logic             Rot   = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             SerOut, Busy, Done;

  int checks = 0, failures = 0;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .D(D), .SerIn(SerIn),
    .Start(Start), .Count(Count),
`ifdef ROTATE_EN
    .Rot(Rot),
`endif
    .Q(Q), .SerOut(SerOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    Mode = 2'b11; D = v; Start = 1'b0;
    step();
    Mode = 2'b00;
  endtask

  initial begin
    int k, busy_n;
    logic seen;

    step(); step();
    chk("rst_q", Q, 8'h00);
    chk("rst_so", SerOut, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Reset = 1'b0;

    // Test 1: reset after a load
    load(8'hA5);
    chk("t1_load", Q, 8'hA5);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("t1_q", Q, 8'h00);
    chk("t1_so", SerOut, 0);
    chk("t1_busy", Busy, 0);
    chk("t1_done", Done, 0);

    // Test 2: single steps
    load(8'h81);
    Mode = 2'b01; SerIn = 1'b1; step();
    chk("t2_shr_q", Q, 8'hC0);
    chk("t2_shr_so", SerOut, 1);
    Mode = 2'b10; SerIn = 1'b0; step();
    chk("t2_shl_q", Q, 8'h80);
    chk("t2_shl_so", SerOut, 1);
    Mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold", Q, 8'h80);
    end

    // Test 3: burst left, Count=3
    load(8'h01);
    Start = 1'b1; Mode = 2'b10; Count = 3; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00;
    chk("t3_q1", Q, 8'h02); chk("t3_b1", Busy, 1);
    step();
    chk("t3_q2", Q, 8'h04); chk("t3_b2", Busy, 1);
    step();
    chk("t3_q3", Q, 8'h08); chk("t3_b3", Busy, 0); chk("t3_d3", Done, 0);
    step();
    chk("t3_done", Done, 1); chk("t3_q4", Q, 8'h08);
    step();
    chk("t3_done_end", Done, 0);

    // Test 4a: Count=0 is a plain step
    Start = 1'b1; Mode = 2'b01; Count = 0; SerIn = 1'b1; step();
    Start = 1'b0; Mode = 2'b00;
    chk("t4a_q", Q, 8'h84); chk("t4a_busy", Busy, 0);
    step();
    chk("t4a_done", Done, 0);

    // Test 4b: Count=1, then a new Start while Done is high
    Start = 1'b1; Mode = 2'b10; Count = 1; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00;
    chk("t4b_q", Q, 8'h08); chk("t4b_so", SerOut, 1); chk("t4b_busy", Busy, 0);
    chk("t4b_d0", Done, 0);
    step();
    chk("t4b_done", Done, 1); chk("t4b_busy2", Busy, 0);
    Start = 1'b1; Mode = 2'b01; Count = 2; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00;
    chk("t4b_rs_q", Q, 8'h04); chk("t4b_rs_busy", Busy, 1); chk("t4b_rs_d", Done, 0);
    step();
    chk("t4b_rs_q2", Q, 8'h02); chk("t4b_rs_b2", Busy, 0);
    step();
    chk("t4b_rs_done", Done, 1);

    // Test 4c: Count=15 clamps to 8 shifts
    load(8'hFF);
    Start = 1'b1; Mode = 2'b01; Count = 15; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00;
    busy_n = 0;
    for (k = 0; k < 20; k++) begin
      if (Done) break;
      if (Busy) busy_n++;
      step();
    end
    chk("t4c_latency", k, 8);
    chk("t4c_busy_n", busy_n, 7);
    chk("t4c_q", Q, 8'h00);
    chk("t4c_so", SerOut, 1);

    // Test 5a: reset mid-burst
    load(8'hFF);
    Start = 1'b1; Mode = 2'b10; Count = 6; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00;
    chk("t5a_q1", Q, 8'hFE);
    step(); step();
    chk("t5a_q3", Q, 8'hF8);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("t5a_q", Q, 8'h00); chk("t5a_busy", Busy, 0); chk("t5a_done", Done, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | Done | Busy;
    end
    chk("t5a_no_done", seen, 0);
    chk("t5a_q_after", Q, 8'h00);

    // Test 5b: Start mid-burst is ignored
    load(8'h01);
    Start = 1'b1; Mode = 2'b10; Count = 3; SerIn = 1'b0; step();
    Mode = 2'b01; Count = 7;
    chk("t5b_q1", Q, 8'h02);
    step();
    Start = 1'b0; Mode = 2'b00;
    chk("t5b_q2", Q, 8'h04);
    step();
    chk("t5b_q3", Q, 8'h08); chk("t5b_busy", Busy, 0);
    step();
    chk("t5b_done", Done, 1); chk("t5b_q4", Q, 8'h08);

`ifdef ROTATE_EN
    // Test 6: rotate-right burst, Rot latched at start
    load(8'h81);
    Start = 1'b1; Mode = 2'b01; Count = 4; Rot = 1'b1; SerIn = 1'b0; step();
    Start = 1'b0; Mode = 2'b00; Rot = 1'b0;
    chk("t6_q1", Q, 8'hC0); chk("t6_so1", SerOut, 1);
    step();
    chk("t6_q2", Q, 8'h60); chk("t6_so2", SerOut, 0);
    step();
    chk("t6_q3", Q, 8'h30); chk("t6_so3", SerOut, 0);
    step();
    chk("t6_q4", Q, 8'h18); chk("t6_so4", SerOut, 0); chk("t6_busy", Busy, 0);
    step();
    chk("t6_done", Done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
